fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that consumes the ProgramCounter outputs and drives its control inputs (pause, we, redirect target). It issues word reads to instruction memory over a req/ack handshake and buffers each returned instruction with its PC in a one-slot output register plus a one-entry skid register. It presents instructions to decode over a valid/ready handshake. ProgramCounter advances exactly once per accepted instruction and is reloaded on a branch redirect.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- i_FetchUnit_PC  in  ADDR_W  current PC from ProgramCounter o_PC
- i_FetchUnit_PC_PLUS  in  ADDR_W  PC+4 from ProgramCounter o_PC_PLUS
- o_FetchUnit_pause  out  1  to ProgramCounter pause; 1 holds PC
- o_FetchUnit_we  out  1  to ProgramCounter we; 1 loads o_FetchUnit_PC
- o_FetchUnit_PC  out  ADDR_W  redirect target to ProgramCounter i_PC
- i_FetchUnit_redirect  in  1  branch/jump taken, one-cycle pulse from execute
- i_FetchUnit_target  in  ADDR_W  redirect target, valid with redirect
- o_imem_req  out  1  memory read request
- o_imem_addr  out  ADDR_W  read address; stable while req high until ack
- i_imem_ack  in  1  read complete; meaningful only while req high; may arrive in the same cycle as req
- i_imem_rdata  in  DATA_W  read data, valid with ack
- o_FetchUnit_valid  out  1  instruction available to decode
- o_FetchUnit_inst  out  DATA_W  instruction word
- o_FetchUnit_inst_pc  out  ADDR_W  address of o_FetchUnit_inst
- o_FetchUnit_pc_plus  out  ADDR_W  inst_pc+4, captured from i_FetchUnit_PC_PLUS
- i_FetchUnit_ready  in  1  decode accepts; transfer when valid&&ready

## Operation
- The FSM has four states: IDLE, FETCH, STALL, FLUSH. Reset enters IDLE. IDLE lasts one cycle with pause=1, then the FSM goes to FETCH.
- FETCH:
  - Drive req=1 and addr=i_FetchUnit_PC.
  - pause=1 until ack arrives.
  - On ack with the slot free (!valid || ready): load the slot with {rdata, PC, PC_PLUS}, drive pause=0 for that cycle, and stay in FETCH.
  - On ack with the slot full and not draining: capture into skid, keep pause=1, and go to STALL.
- STALL:
  - Drive req=0 and pause=1.
  - When ready: move skid into the slot, drive pause=0 for that cycle, and go to FETCH.
- Redirect has highest priority in every state:
  - Drive we=1, o_FetchUnit_PC=target, and pause=0 in that cycle.
  - Clear slot valid and skid, and drop any valid&&ready transfer of that cycle (decode kills its own copy).
  - If in FETCH with req high and no ack in that cycle: latch i_FetchUnit_PC into flush_addr and go to FLUSH.
  - Otherwise go to FETCH.
- FLUSH:
  - Drive req=1 and addr=flush_addr, with pause=1.
  - On ack: discard the data and go to FETCH.
  - A redirect during FLUSH still loads the PC; the FSM stays in FLUSH.
- Instruction data is never altered. Alignment is not checked.

## Timing
- Reset values:
  - o_FetchUnit_valid=0; inst, inst_pc, pc_plus = 0
  - o_imem_req=0, o_imem_addr=0
  - o_FetchUnit_pause=1, o_FetchUnit_we=0, o_FetchUnit_PC=0
  - skid empty
- Outputs to memory and to the PC are combinational from state and current inputs. Slot and skid are registered.
- Latency: an instruction is valid the cycle after its ack. With zero-wait memory (ack in the request cycle) and ready held at 1, throughput is one instruction per cycle.
- Per PC value, the PC sees pause=0 in exactly one cycle, so no instruction is skipped or duplicated.
- Redirect and ack in the same cycle: the ack data is discarded and no FLUSH is entered.
- Redirect while in STALL: the skid is discarded with no memory effect.
- rst asserted mid-request: the FSM drops req immediately. Memory must tolerate an abandoned request.

## Structure
- The shared package (cpu_pkg) holds:
  - the FSM state encoding localparams (2 bits: IDLE=0, FETCH=1, STALL=2, FLUSH=3);
  - ADDR_W and DATA_W defaults;
  - the fetch-packet field widths.
- One natural sub-module: fetch_skid_buffer, which holds the output slot and skid register and provides valid/ready, load, and flush.
- The FSM and the PC/memory control stay in fetch_unit.

## Test plan
- **Zero-wait run:** reset, PC=0x0, ack same cycle, ready=1 → inst_pc 0x0, 0x4, 0x8 on consecutive cycles; pause low every FETCH cycle after IDLE.
- **Wait states:** ack delayed 3 cycles at PC=0x10 → req/addr=0x10 stable for 4 cycles, pause=1 for 3 of them; valid with inst=rdata and inst_pc=0x10 one cycle after ack.
- **Backpressure:** ready=0 for 4 cycles after the first instruction → the second instruction goes to skid and the FSM enters STALL with req=0 and pause=1. Releasing ready yields 0x4, then 0x8, with none lost or duplicated.
- **Redirect idle:** redirect with target 0x12345678 while in STALL → we=1 and o_FetchUnit_PC=0x12345678 for one cycle, valid cleared. The next request has addr 0x12345678.
- **Redirect mid-request:** redirect while req is pending at 0x20 → FLUSH holds addr 0x20 until ack and the data is discarded. The following request goes to the target.
- **Async reset:** rst raised mid-FLUSH → valid=0, req=0, pause=1 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch definitions: FSM encoding, default widths and fetch-packet layout.
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  // Fetch packet is {inst, inst_pc, pc_plus}, MSB first.
  localparam int INST_FIELD_W    = DATA_W_DEF;
  localparam int PC_FIELD_W      = ADDR_W_DEF;
  localparam int PC_PLUS_FIELD_W = ADDR_W_DEF;

  function automatic int pkt_w(input int aw, input int dw);
    return dw + 2 * aw;
  endfunction
endpackage

// File: rtl/fetch_skid_buffer.sv
// Output slot plus one-entry skid register holding fetched {inst, pc, pc_plus} packets.
module fetch_skid_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load_slot,
  input  logic              load_skid,
  input  logic              move_skid,
  input  logic              ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_pc_plus,
  output logic              valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus
);
  localparam int PW = pkt_w(ADDR_W, DATA_W);

  logic [PW-1:0] slot;
  logic [PW-1:0] skid;
  logic [PW-1:0] in_pkt;
  logic          skid_valid;

  assign in_pkt = {in_inst, in_pc, in_pc_plus};
  assign {inst, inst_pc, pc_plus} = slot;

  // Flush wins over everything, including a transfer decode sees this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= '0;
      skid       <= '0;
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_slot) begin
      slot  <= in_pkt;
      valid <= 1'b1;
    end else if (load_skid) begin
      skid       <= in_pkt;
      skid_valid <= 1'b1;
    end else if (move_skid && skid_valid) begin
      slot       <= skid;
      valid      <= 1'b1;
      skid_valid <= 1'b0;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives ProgramCounter, issues imem reads, buffers results for decode.
// Handshakes: imem transfer when req&&ack (addr held while req&&!ack); decode transfer when valid&&ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_FetchUnit_PC,
  input  logic [ADDR_W-1:0] i_FetchUnit_PC_PLUS,
  output logic              o_FetchUnit_pause,
  output logic              o_FetchUnit_we,
  output logic [ADDR_W-1:0] o_FetchUnit_PC,
  input  logic              i_FetchUnit_redirect,
  input  logic [ADDR_W-1:0] i_FetchUnit_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_FetchUnit_valid,
  output logic [DATA_W-1:0] o_FetchUnit_inst,
  output logic [ADDR_W-1:0] o_FetchUnit_inst_pc,
  output logic [ADDR_W-1:0] o_FetchUnit_pc_plus,
  input  logic              i_FetchUnit_ready,
  output logic [1:0]        dbg_state
);
  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] flush_addr;
  logic              latch_flush;
  logic              redir;
  logic              slot_free;
  logic              load_slot;
  logic              load_skid;
  logic              move_skid;
  logic              flush;

  assign dbg_state = state;
  assign redir     = i_FetchUnit_redirect && !rst;
  assign slot_free = !o_FetchUnit_valid || i_FetchUnit_ready;

  always_comb begin
    next_state        = state;
    o_imem_req        = 1'b0;
    o_imem_addr       = '0;
    o_FetchUnit_pause = 1'b1;
    o_FetchUnit_we    = 1'b0;
    o_FetchUnit_PC    = '0;
    load_slot         = 1'b0;
    load_skid         = 1'b0;
    move_skid         = 1'b0;
    flush             = 1'b0;
    latch_flush       = 1'b0;
    case (state)
      ST_IDLE: next_state = ST_FETCH;
      ST_FETCH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = i_FetchUnit_PC;
        if (i_imem_ack) begin
          if (slot_free) begin
            load_slot         = 1'b1;
            o_FetchUnit_pause = 1'b0;
          end else begin
            load_skid  = 1'b1;
            next_state = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (i_FetchUnit_ready) begin
          move_skid         = 1'b1;
          o_FetchUnit_pause = 1'b0;
          next_state        = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = flush_addr;
        if (i_imem_ack) next_state = ST_FETCH;
      end
      default: next_state = ST_IDLE;
    endcase
    // A pending request cannot be withdrawn, so it is finished in FLUSH and its data dropped.
    if (redir) begin
      o_FetchUnit_we    = 1'b1;
      o_FetchUnit_PC    = i_FetchUnit_target;
      o_FetchUnit_pause = 1'b0;
      flush             = 1'b1;
      load_slot         = 1'b0;
      load_skid         = 1'b0;
      move_skid         = 1'b0;
      if (state == ST_FETCH && !i_imem_ack) begin
        latch_flush = 1'b1;
        next_state  = ST_FLUSH;
      end else if (state == ST_FLUSH && !i_imem_ack) begin
        next_state = ST_FLUSH;
      end else begin
        next_state = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_addr <= '0;
    end else begin
      state <= next_state;
      if (latch_flush) flush_addr <= i_FetchUnit_PC;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load_slot  (load_slot),
    .load_skid  (load_skid),
    .move_skid  (move_skid),
    .ready      (i_FetchUnit_ready),
    .in_inst    (i_imem_rdata),
    .in_pc      (i_FetchUnit_PC),
    .in_pc_plus (i_FetchUnit_PC_PLUS),
    .valid      (o_FetchUnit_valid),
    .inst       (o_FetchUnit_inst),
    .inst_pc    (o_FetchUnit_inst_pc),
    .pc_plus    (o_FetchUnit_pc_plus)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a ProgramCounter model and a gated zero-wait memory.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        pause;
  logic        we;
  logic [31:0] pc_load;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic        ack_en = 1'b0;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus;
  logic        ready = 1'b0;
  logic [1:0]  state;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // ProgramCounter model and memory that answers whenever ack_en is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (we) pc <= pc_load;
    else if (!pause) pc <= pc + 32'd4;
  end
  assign pc_plus = pc + 32'd4;
  assign ack     = req && ack_en;
  assign rdata   = addr ^ K;

  fetch_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_FetchUnit_PC       (pc),
    .i_FetchUnit_PC_PLUS  (pc_plus),
    .o_FetchUnit_pause    (pause),
    .o_FetchUnit_we       (we),
    .o_FetchUnit_PC       (pc_load),
    .i_FetchUnit_redirect (redirect),
    .i_FetchUnit_target   (target),
    .o_imem_req           (req),
    .o_imem_addr          (addr),
    .i_imem_ack           (ack),
    .i_imem_rdata         (rdata),
    .o_FetchUnit_valid    (valid),
    .o_FetchUnit_inst     (inst),
    .o_FetchUnit_inst_pc  (inst_pc),
    .o_FetchUnit_pc_plus  (inst_pc_plus),
    .i_FetchUnit_ready    (ready),
    .dbg_state            (state)
  );

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; target = '0; ready = 1'b0; ack_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; ready = 1'b0; ack_en = 1'b0;
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if ({inst, inst_pc, inst_pc_plus} !== 96'd0) begin errors++; $display("FAIL reset_slot: got %h %h %h want 0", inst, inst_pc, inst_pc_plus); end
    checks++; if (req !== 1'b0 || addr !== 32'd0) begin errors++; $display("FAIL reset_mem: got req=%b addr=%h want 0/0", req, addr); end
    checks++; if (pause !== 1'b1 || we !== 1'b0 || pc_load !== 32'd0) begin errors++; $display("FAIL reset_pc_ctl: got pause=%b we=%b pc=%h want 1/0/0", pause, we, pc_load); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (state !== ST_IDLE || pause !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL idle: got st=%0d pause=%b req=%b want 0/1/0", state, pause, req); end
    @(negedge clk); #1;
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL idle_to_fetch: got st=%0d want 1", state); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    ready = 1'b1; ack_en = 1'b1;
    @(negedge clk); #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0 || pause !== 1'b0) begin errors++; $display("FAIL zw_first: got req=%b addr=%h pause=%b want 1/0/0", req, addr, pause); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== (32'(4 * i) ^ K) || inst_pc_plus !== 32'(4 * i + 4)) begin
        errors++; $display("FAIL zw_inst%0d: got v=%b pc=%h inst=%h pp=%h want pc=%h", i, valid, inst_pc, inst, inst_pc_plus, 32'(4 * i));
      end
      checks++; if (pause !== 1'b0) begin errors++; $display("FAIL zw_pause%0d: got %b want 0", i, pause); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    redirect = 1'b1; target = 32'h10; #1;
    checks++; if (we !== 1'b1 || pc_load !== 32'h10 || pause !== 1'b0) begin errors++; $display("FAIL ws_redir: got we=%b pc=%h pause=%b want 1/10/0", we, pc_load, pause); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); redirect = 1'b0; ack_en = (i == 3); #1;
      checks++; if (req !== 1'b1 || addr !== 32'h10 || pause !== (i != 3)) begin
        errors++; $display("FAIL ws_hold%0d: got req=%b addr=%h pause=%b want 1/10/%b", i, req, addr, pause, (i != 3));
      end
    end
    @(negedge clk); ack_en = 1'b0; #1;
    checks++; if (valid !== 1'b1 || inst !== (32'h10 ^ K) || inst_pc !== 32'h10 || inst_pc_plus !== 32'h14) begin
      errors++; $display("FAIL ws_data: got v=%b inst=%h pc=%h pp=%h want 1/%h/10/14", valid, inst, inst_pc, inst_pc_plus, 32'h10 ^ K);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (pause !== 1'b1 || valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_skid: got pause=%b v=%b pc=%h want 1/1/0", pause, valid, inst_pc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (state !== ST_STALL || req !== 1'b0 || pause !== 1'b1 || inst_pc !== 32'h0) begin
        errors++; $display("FAIL bp_stall%0d: got st=%0d req=%b pause=%b pc=%h want 2/0/1/0", i, state, req, pause, inst_pc);
      end
    end
    @(negedge clk); ready = 1'b1; #1;
    checks++; if (pause !== 1'b0 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_release: got pause=%b pc=%h want 0/0", pause, inst_pc); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== (32'(4 * i) ^ K)) begin
        errors++; $display("FAIL bp_order%0d: got v=%b pc=%h inst=%h want pc=%h", i, valid, inst_pc, inst, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    ack_en = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    redirect = 1'b1; target = 32'h1234_5678; #1;
    checks++; if (state !== ST_STALL || we !== 1'b1 || pc_load !== 32'h1234_5678 || pause !== 1'b0) begin
      errors++; $display("FAIL rs_redir: got st=%0d we=%b pc=%h pause=%b want 2/1/12345678/0", state, we, pc_load, pause);
    end
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (we !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rs_clear: got we=%b v=%b want 0/0", we, valid); end
    checks++; if (state !== ST_FETCH || req !== 1'b1 || addr !== 32'h1234_5678) begin
      errors++; $display("FAIL rs_next: got st=%0d req=%b addr=%h want 1/1/12345678", state, req, addr);
    end
  endtask

  task automatic test_redirect_midreq();
    do_reset();
    redirect = 1'b1; target = 32'h20;
    @(negedge clk); redirect = 1'b0;
    @(negedge clk); redirect = 1'b1; target = 32'h100; #1;
    checks++; if (we !== 1'b1 || pause !== 1'b0 || addr !== 32'h20) begin errors++; $display("FAIL rm_redir: got we=%b pause=%b addr=%h want 1/0/20", we, pause, addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); redirect = 1'b0; ack_en = (i == 2); #1;
      checks++; if (state !== ST_FLUSH || req !== 1'b1 || addr !== 32'h20 || pause !== 1'b1) begin
        errors++; $display("FAIL rm_flush%0d: got st=%0d req=%b addr=%h pause=%b want 3/1/20/1", i, state, req, addr, pause);
      end
    end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0 || state !== ST_FETCH || addr !== 32'h100) begin
      errors++; $display("FAIL rm_after: got v=%b st=%0d addr=%h want 0/1/100", valid, state, addr);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    ack_en = 1'b1; ready = 1'b1;
    @(negedge clk);
    @(negedge clk); redirect = 1'b1; target = 32'h40; #1;
    checks++; if (we !== 1'b1 || valid !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL ra_redir: got we=%b v=%b ack=%b want 1/1/1", we, valid, ack); end
    @(negedge clk); redirect = 1'b0; ack_en = 1'b0; #1;
    checks++; if (state !== ST_FETCH || valid !== 1'b0 || addr !== 32'h40) begin
      errors++; $display("FAIL ra_next: got st=%0d v=%b addr=%h want 1/0/40", state, valid, addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); redirect = 1'b1; target = 32'h80;
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (state !== ST_FLUSH || req !== 1'b1) begin errors++; $display("FAIL ar_setup: got st=%0d req=%b want 3/1", state, req); end
    #1 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0 || pause !== 1'b1 || state !== ST_IDLE) begin
      errors++; $display("FAIL ar_async: got v=%b req=%b pause=%b st=%0d want 0/0/1/0", valid, req, pause, state);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_redirect_stall();
    test_redirect_midreq();
    test_redirect_ack();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
